enc_gray_codec_pipe: RTL

//  Parametrised, pipelined Gray-code engine for the encoder library. It converts

---
 rtl/enc_gray_codec_pipe.sv | 134 +++++++++++++
 1 files changed

// File: rtl/enc_gray_codec_pipe.sv
// Pipelined Gray-code engine: bin2gray, gray2bin, Gray increment or pass-through,
// one beat per clock behind valid/ready handshakes on both sides.
// The gray2bin prefix-XOR chain is cut into ceil(WIDTH/STAGES)-bit slices, MSB
// slice first, one slice per stage. The increment and re-encode run in the last stage.
module enc_gray_codec_pipe #(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int SL   = (WIDTH + STAGES - 1) / STAGES;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] st_valid;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_valid;
  logic [1:0]        st_mode  [STAGES];
  logic [WIDTH-1:0]  st_data  [STAGES];
  logic [WIDTH-1:0]  st_bin   [STAGES];
  logic [1:0]        src_mode [STAGES];
  logic [WIDTH-1:0]  src_data [STAGES];
  logic [WIDTH-1:0]  src_bin  [STAGES];
  logic [WIDTH-1:0]  nxt_data [STAGES];
  logic [WIDTH-1:0]  nxt_bin  [STAGES];

  // Resolve the bits of slice k of the prefix XOR; bits above the slice are
  // already resolved in b_in and feed the running carry.
  function automatic logic [WIDTH-1:0] slice_step(input int k,
                                                  input logic [WIDTH-1:0] g,
                                                  input logic [WIDTH-1:0] b_in);
    logic [WIDTH-1:0] b;
    logic             prev;
    b    = b_in;
    prev = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if ((i <= WIDTH - 1 - k * SL) && (i > WIDTH - 1 - (k + 1) * SL))
        b[i] = prev ^ g[i];
      prev = b[i];
    end
    return b;
  endfunction

  // Final per-mode result once the full binary value is known.
  function automatic logic [WIDTH-1:0] finish_op(input logic [1:0] m,
                                                 input logic [WIDTH-1:0] d,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] r;
    t = b + WIDTH'(1);
    case (m)
      2'b00:   r = d ^ (d >> 1);
      2'b01:   r = b;
      2'b10:   r = t ^ (t >> 1);
      default: r = d;
    endcase
    return r;
  endfunction

  // Stage k loads when it is empty or its content moves on; the last stage
  // moves on when the consumer takes the result.
  always_comb begin
    logic chain;
    chain = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = !st_valid[k] || chain;
      chain   = load[k];
    end
  end

  assign in_ready = !rst && load[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign src_valid[k] = in_valid && in_ready;
      assign src_mode[k]  = in_mode;
      assign src_data[k]  = in_data;
      assign src_bin[k]   = '0;
    end else begin : g_next
      assign src_valid[k] = st_valid[k-1];
      assign src_mode[k]  = st_mode[k-1];
      assign src_data[k]  = st_data[k-1];
      assign src_bin[k]   = st_bin[k-1];
    end

    assign nxt_bin[k] = slice_step(k, src_data[k], src_bin[k]);

    if (k == LAST) begin : g_last
      assign nxt_data[k] = finish_op(src_mode[k], src_data[k], nxt_bin[k]);
    end else begin : g_pass
      assign nxt_data[k] = src_data[k];
    end
  end

  // Stage registers: valid follows the upstream beat on load, payload only
  // changes when a real beat arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        st_mode[k] <= '0;
        st_data[k] <= '0;
        st_bin[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          st_valid[k] <= src_valid[k];
          if (src_valid[k]) begin
            st_mode[k] <= src_mode[k];
            st_data[k] <= nxt_data[k];
            st_bin[k]  <= nxt_bin[k];
          end
        end
      end
    end
  end

  assign out_valid = st_valid[LAST];
  assign out_mode  = st_mode[LAST];
  assign out_data  = st_data[LAST];
  assign busy      = |st_valid;

endmodule
